// File: rtl/spi_pixel_receiver.sv
// spi_pixel_receiver: SPI pixel link receiver with RGB decode and AXI-stream output FIFO
module spi_pixel_receiver #(
  parameter int PIXEL         = 128*128,
  parameter int WORD_WIDTH    = 16,
  parameter bit DECODE_RGB444 = 1'b1,
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        mosi,
  input  logic        startReceive,
  output logic        receiveRunning,
  output logic        overflow,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] m_axis_tdata
);
  localparam int BW = $clog2(WORD_WIDTH);
  localparam int PW = $clog2(PIXEL + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, RECEIVE} state_t;
  state_t                state_q;
  logic [2:0]            sck_q;
  logic [1:0]            mosi_q;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q;
  logic [PW-1:0]         pix_q;
  logic [TW-1:0]         timer_q;
  logic                  push_q, push_last_q;
  logic [16:0]           mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_q, rd_q;
  logic                  sck_rise, word_done, timed_out, full, empty, pop, push_ok;
  logic [15:0]           w16, dec_word;
  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign shift_d   = {shift_q[WORD_WIDTH-2:0], mosi_q[1]};
  assign word_done = state_q == RECEIVE && sck_rise && bit_q == BW'(WORD_WIDTH - 1);
  assign timed_out = state_q == RECEIVE && timer_q == TW'(TIMEOUT) && bit_q != '0;
  assign w16       = 16'(shift_q);
  assign dec_word  = (WORD_WIDTH == 16 && DECODE_RGB444) ? {4'h0, w16[15:12], w16[10:7], w16[4:1]} : w16;
  assign empty     = wr_q == rd_q;
  assign full      = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
  assign pop       = !empty && m_axis_tready;
  assign push_ok   = push_q && (!full || pop);
  assign m_axis_tvalid = !empty;
  assign {m_axis_tlast, m_axis_tdata} = mem_q[rd_q[AW-1:0]];
  // two-flop synchronisers plus one extra sck stage for rising-edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sck_q  <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      mosi_q <= {mosi_q[0], mosi};
    end
  // frame FSM: bit/pixel counting, idle timeout, push staging and sticky overflow
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q        <= IDLE;
      receiveRunning <= 1'b0;
      overflow       <= 1'b0;
      shift_q        <= '0;
      bit_q          <= '0;
      pix_q          <= '0;
      timer_q        <= '0;
      push_q         <= 1'b0;
      push_last_q    <= 1'b0;
    end else begin
      push_q <= word_done;
      if (word_done) push_last_q <= pix_q == PW'(PIXEL - 1);
      if (push_q && !push_ok) overflow <= 1'b1;
      if (state_q == IDLE) begin
        shift_q <= '0;
        timer_q <= '0;
        if (startReceive) begin
          state_q        <= RECEIVE;
          receiveRunning <= 1'b1;
          bit_q          <= '0;
          pix_q          <= '0;
          overflow       <= 1'b0;
        end
      end else begin
        timer_q <= sck_rise ? '0 : (timer_q == TW'(TIMEOUT) ? timer_q : timer_q + 1'b1);
        if (sck_rise) begin
          shift_q <= shift_d;
          bit_q   <= word_done ? '0 : bit_q + 1'b1;
          if (word_done) pix_q <= pix_q + 1'b1;
        end else if (timed_out) bit_q <= '0;
        if (push_q && push_last_q) begin
          state_q        <= IDLE;
          receiveRunning <= 1'b0;
        end
      end
    end
  // output FIFO; a simultaneous pop frees the slot a full-FIFO push needs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q[AW-1:0]] <= {push_last_q, dec_word};
        wr_q                <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
endmodule

// File: tb/tb_spi_pixel_receiver.sv
// tb_spi_pixel_receiver: scoreboard bench for decode-on, decode-off and 12-bit receivers
module tb_spi_pixel_receiver;
  localparam int PIX = 4;
  logic clk = 0, reset = 1, sck = 0, mosi = 0, start_ab = 0, start_c = 0, tready = 1;
  logic run_a, ovf_a, tv_a, tl_a, run_b, ovf_b, tv_b, tl_b, run_c, ovf_c, tv_c, tl_c;
  logic [15:0] td_a, td_b, td_c;
  logic [16:0] qa[$], qb[$], qc[$];
  int n_chk = 0, n_pass = 0, pix = 0;
  always #5 clk = ~clk;
  spi_pixel_receiver #(.PIXEL(PIX), .WORD_WIDTH(16), .DECODE_RGB444(1), .FIFO_DEPTH(4), .TIMEOUT(64)) u_a (
    .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .startReceive(start_ab), .receiveRunning(run_a),
    .overflow(ovf_a), .m_axis_tvalid(tv_a), .m_axis_tready(tready), .m_axis_tlast(tl_a), .m_axis_tdata(td_a));
  spi_pixel_receiver #(.PIXEL(PIX), .WORD_WIDTH(16), .DECODE_RGB444(0), .FIFO_DEPTH(4), .TIMEOUT(64)) u_b (
    .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .startReceive(start_ab), .receiveRunning(run_b),
    .overflow(ovf_b), .m_axis_tvalid(tv_b), .m_axis_tready(tready), .m_axis_tlast(tl_b), .m_axis_tdata(td_b));
  spi_pixel_receiver #(.PIXEL(PIX), .WORD_WIDTH(12), .DECODE_RGB444(1), .FIFO_DEPTH(4), .TIMEOUT(64)) u_c (
    .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .startReceive(start_c), .receiveRunning(run_c),
    .overflow(ovf_c), .m_axis_tvalid(tv_c), .m_axis_tready(tready), .m_axis_tlast(tl_c), .m_axis_tdata(td_c));
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask
  function automatic logic [15:0] dec(input logic [15:0] w);
    return {4'h0, w[15:12], w[10:7], w[4:1]};
  endfunction
  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sck = 0;
      mosi = w[i];
      repeat (2) @(negedge clk);
      sck = 1;
      repeat (2) @(negedge clk);
    end
  endtask
  task automatic expect_word(input logic [15:0] w, input bit drop);
    if (!drop) begin
      qa.push_back({pix == PIX - 1, dec(w)});
      qb.push_back({pix == PIX - 1, w});
    end
    pix++;
  endtask
  task automatic send_word(input logic [15:0] w, input bit drop);
    expect_word(w, drop);
    send_bits(w, 16);
  endtask
  task automatic pulse_start();
    @(negedge clk) start_ab = 1;
    @(negedge clk) start_ab = 0;
  endtask
  task automatic arm();
    pulse_start();
    pix = 0;
  endtask
  always @(negedge clk)
    if (!reset) begin
      if (tv_a && tready) begin
        if (qa.size() == 0) chk("a_unexpected_beat", tv_a, 0);
        else chk("a_beat", {15'd0, tl_a, td_a}, {15'd0, qa.pop_front()});
      end
      if (tv_b && tready) begin
        if (qb.size() == 0) chk("b_unexpected_beat", tv_b, 0);
        else chk("b_beat", {15'd0, tl_b, td_b}, {15'd0, qb.pop_front()});
      end
      if (tv_c && tready) begin
        if (qc.size() == 0) chk("c_unexpected_beat", tv_c, 0);
        else chk("c_beat", {15'd0, tl_c, td_c}, {15'd0, qc.pop_front()});
      end
    end
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_running", run_a, 0);
    chk("rst_overflow", ovf_a, 0);
    chk("rst_tvalid", tv_a, 0);
    chk("rst_tlast", tl_a, 0);
    chk("rst_tdata", td_a, 0);
    chk("rst_tvalid_b", tv_b, 0);
    chk("rst_tvalid_c", tv_c, 0);
    reset = 0;
    send_bits(16'hFFFF, 16);
    sck = 0;
    repeat (12) @(negedge clk);
    chk("unarmed_tvalid", tv_a, 0);
    chk("unarmed_running", run_a, 0);
    arm();
    chk("armed_running", run_a, 1);
    send_word(16'hF7BE, 0);
    send_word(16'h0000, 0);
    pulse_start();
    send_word(16'h8422, 0);
    expect_word(16'hFFFF, 0);
    send_bits(16'hFFFF, 16);
    @(negedge clk);
    chk("last_running_before_push", run_a, 1);
    chk("last_tvalid_before_push", tv_a, 0);
    @(negedge clk);
    chk("last_running_after_push", run_a, 0);
    chk("last_tvalid_after_push", tv_a, 1);
    chk("last_tlast", tl_a, 1);
    repeat (4) @(negedge clk);
    @(posedge clk) #1 tready = 0;
    arm();
    send_word(16'hA5C3, 0);
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    send_word(16'h3333, 0);
    repeat (4) @(negedge clk);
    chk("full_no_overflow", ovf_a, 0);
    chk("full_tvalid", tv_a, 1);
    chk("frame2_done", run_a, 0);
    arm();
    send_word(16'h4444, 1);
    repeat (4) @(negedge clk);
    chk("overflow_set", ovf_a, 1);
    chk("overflow_set_b", ovf_b, 1);
    @(posedge clk) #1 tready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_tvalid", tv_a, 1);
    end
    @(negedge clk);
    chk("drain_empty", tv_a, 0);
    chk("drain_queue", qa.size(), 0);
    chk("overflow_sticky", ovf_a, 1);
    send_bits(16'h0055, 7);
    repeat (70) @(negedge clk);
    chk("timeout_no_beat", tv_a, 0);
    chk("timeout_running", run_a, 1);
    send_word(16'h1234, 0);
    send_word(16'hABCD, 0);
    send_word(16'h5678, 0);
    repeat (6) @(negedge clk);
    chk("frame3_done", run_a, 0);
    chk("frame3_queue", qb.size(), 0);
    arm();
    chk("overflow_cleared_on_arm", ovf_a, 0);
    chk("frame4_running", run_a, 1);
    @(posedge clk) #1 tready = 0;
    send_word(16'hC3C3, 0);
    send_bits(16'h01FF, 9);
    chk("pre_reset_tvalid", tv_a, 1);
    #2 reset = 1;
    #1;
    chk("midrst_running", run_a, 0);
    chk("midrst_tvalid", tv_a, 0);
    chk("midrst_tlast", tl_a, 0);
    chk("midrst_tdata", td_a, 0);
    chk("midrst_overflow", ovf_a, 0);
    chk("midrst_tvalid_b", tv_b, 0);
    qa.delete();
    qb.delete();
    tready = 1;
    @(negedge clk) reset = 0;
    send_bits(16'hFFFF, 16);
    sck = 0;
    repeat (10) @(negedge clk);
    chk("post_reset_idle_tvalid", tv_a, 0);
    chk("post_reset_idle_running", run_a, 0);
    arm();
    send_word(16'h0F0F, 0);
    repeat (6) @(negedge clk);
    @(negedge clk) start_c = 1;
    @(negedge clk) start_c = 0;
    chk("c_running", run_c, 1);
    qc.push_back({1'b0, 16'h0ABC});
    send_bits(16'h0ABC, 12);
    sck = 0;
    repeat (80) @(negedge clk);
    chk("end_queue_a", qa.size(), 0);
    chk("end_queue_b", qb.size(), 0);
    chk("end_queue_c", qc.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
